gate_lut_sweeper: RTL and testbench
===================================

Name: gate_lut_sweeper

Overview:
- Parametrised successor to the fixed two-input gate exercises (e.g. s = a | ~b).
- Evaluates any N-input boolean function held in a loadable truth-table register (LUT).
- Two registered modes:
  - single evaluation of an external input vector;
  - self-driven sweep of all 2^N minterms, with a ones count. This replaces the hand-written stimulus loops in gate testbenches.

Parameters:
- N, 2, number of function inputs (1..6).
- TT_RST, 4'b1101, truth table loaded at reset, width 2^N. Bit m = output for minterm m. Default is a | ~b with m = {a,b}.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- tt_load  in  1  load tt_in into LUT.
- tt_in  in  2^N  new truth table.
- in_valid  in  1  request single evaluation of in_x.
- in_x  in  N  input vector; in_x[N-1] is the MSB input ("a"), so minterm = in_x.
- start  in  1  request full minterm sweep.
- tt  out  2^N  current LUT contents.
- out_valid  out  1  out_m/out_s valid this cycle.
- out_m  out  N  minterm evaluated.
- out_s  out  1  function value tt[out_m].
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last sweep output.
- ones_cnt  out  N+1  running/final count of minterms with s=1 in the current/last sweep.

Behaviour:
- Reset (rst_n=0 at an edge):
  - tt=TT_RST.
  - out_valid, out_m, out_s, busy, done, ones_cnt all 0.
  - Internal minterm counter 0.
  - Reset overrides every other input.
  - Reset mid-sweep aborts the sweep: no done, no further outputs.
- States: IDLE, SWEEP. A DONE pulse is emitted on the SWEEP->IDLE edge.
- IDLE, priority at each edge: tt_load > start > in_valid.
  - tt_load=1: tt<=tt_in. start and in_valid are ignored that cycle; out_valid<=0.
  - start=1:
    - Enter SWEEP: busy<=1, out_valid<=1, out_m<=0, out_s<=tt[0], ones_cnt<=tt[0].
    - Counter<=1.
    - in_valid is ignored.
  - in_valid=1:
    - out_valid<=1, out_m<=in_x, out_s<=tt[in_x] (LUT value before this edge).
    - ones_cnt is unchanged.
    - Latency is 1 cycle.
  - Otherwise: out_valid<=0.
- SWEEP, each edge with counter c:
  - If c <= 2^N-1:
    - out_valid<=1, out_m<=c, out_s<=tt[c], ones_cnt<=ones_cnt+tt[c].
    - c<=c+1 (counter is N+1 bits wide, so no wrap).
  - If c == 2^N:
    - busy<=0, out_valid<=0, done<=1.
    - Return to IDLE.
    - ones_cnt holds popcount(tt).
  - busy is high for exactly 2^N cycles. Outputs appear in ascending order, one per cycle.
  - tt_load, start and in_valid are ignored while busy. The LUT is stable for the whole sweep.
- done is high for exactly one cycle, then 0.
  - A start sampled in the same cycle that done is high is accepted normally.
  - ones_cnt is cleared only by a new sweep start or by reset.
- out_m and out_s hold their last values when out_valid=0; consumers qualify with out_valid.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 edges.
  - Required: tt=4'b1101; out_valid, out_s, busy, done, ones_cnt = 0. Hold rst_n=1 with idle inputs: outputs remain 0.
- Single eval, default table:
  - Stimulus: in_x = 00, 01, 10, 11 on consecutive cycles with in_valid=1.
  - Required: one cycle later each, out_valid=1 with out_s = 1, 0, 1, 1 and out_m echoing in_x.
- Default sweep:
  - Stimulus: start pulse.
  - Required:
    - Next 4 edges give out_m = 0..3, out_s = 1, 0, 1, 1; ones_cnt = 1, 1, 2, 3; busy=1.
    - 5th edge: busy=0, done=1, ones_cnt=3.
    - 6th edge: done=0.
- Reload then sweep:
  - Stimulus: tt_load with tt_in=4'b0110 (XOR), then start.
  - Required: out_s = 0, 1, 1, 0; final ones_cnt=2; tt=4'b0110.
- Collisions:
  - start+tt_load in the same cycle: tt updated, busy stays 0.
  - in_valid+tt_load in the same cycle: no out_valid.
  - in_valid, start or tt_load during a sweep: ignored. Exactly 4 out_valid cycles, tt unchanged.
  - start in the done cycle: a new sweep begins.
- Reset mid-sweep:
  - Stimulus: rst_n=0 after out_m=1.
  - Required: next edge busy=0, out_valid=0, ones_cnt=0, tt=4'b1101; no done pulse ever appears.

Source files
------------

// File: rtl/gate_lut_sweeper.sv
// gate_lut_sweeper
// Evaluates an arbitrary N-input boolean function stored in a loadable
// truth-table register (LUT). There are two modes:
//   - single evaluation of an external input vector, with one cycle of latency;
//   - a self-driven sweep of all 2^N minterms in ascending order, which keeps
//     a running count of how many minterms evaluate to 1.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      synchronous active-low reset; overrides every other input
//   i_tt_load    load i_tt_in into the LUT (only while idle)
//   i_tt_in      new truth table; bit m is the output for minterm m
//   i_in_valid   request a single evaluation of i_in_x (only while idle)
//   i_in_x       input vector; i_in_x[N-1] is the MSB input, so minterm = i_in_x
//   i_start      request a full minterm sweep (only while idle)
//   o_tt         current LUT contents
//   o_out_valid  o_out_m / o_out_s are valid this cycle
//   o_out_m      minterm that was evaluated
//   o_out_s      function value o_tt[o_out_m]
//   o_busy       sweep in progress (high for exactly 2^N cycles)
//   o_done       one-cycle pulse after the last sweep output
//   o_ones_cnt   running or final count of ones in the current or last sweep
module gate_lut_sweeper #(
    parameter int                    N      = 2,
    parameter logic [(2**N)-1:0]     TT_RST = 4'b1101
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tt_load,
    input  logic [(2**N)-1:0]     i_tt_in,
    input  logic                  i_in_valid,
    input  logic [N-1:0]          i_in_x,
    input  logic                  i_start,
    output logic [(2**N)-1:0]     o_tt,
    output logic                  o_out_valid,
    output logic [N-1:0]          o_out_m,
    output logic                  o_out_s,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N:0]            o_ones_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                r_state;
    logic [(2**N)-1:0]     r_tt;
    logic [N:0]            r_cnt;        // N+1 bits so 2^N is reachable without wrapping
    logic                  r_out_valid;
    logic [N-1:0]          r_out_m;
    logic                  r_out_s;
    logic                  r_busy;
    logic                  r_done;
    logic [N:0]            r_ones_cnt;

    // Widened LUT bit for the current sweep minterm, added to the ones count.
    logic [N:0]            w_sweep_bit;

    // Zero-extend the LUT bit selected by the sweep counter.
    always_comb begin
        w_sweep_bit = {(N+1){1'b0}};
        if (r_cnt[N] == 1'b0) begin
            w_sweep_bit[0] = r_tt[r_cnt[N-1:0]];
        end else begin
            w_sweep_bit[0] = 1'b0;
        end
    end

    // Control FSM together with the LUT and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_tt        <= TT_RST;
            r_cnt       <= {(N+1){1'b0}};
            r_out_valid <= 1'b0;
            r_out_m     <= {N{1'b0}};
            r_out_s     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ones_cnt  <= {(N+1){1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_tt_load) begin
                        // A table load wins over start and in_valid in the same cycle.
                        r_tt        <= i_tt_in;
                        r_out_valid <= 1'b0;
                    end else if (i_start) begin
                        // Minterm 0 is produced on the start edge itself; the counter moves to 1.
                        r_state     <= ST_SWEEP;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_m     <= {N{1'b0}};
                        r_out_s     <= r_tt[0];
                        r_ones_cnt  <= {{N{1'b0}}, r_tt[0]};
                        r_cnt       <= {{N{1'b0}}, 1'b1};
                    end else if (i_in_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_m     <= i_in_x;
                        r_out_s     <= r_tt[i_in_x];
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt[N] == 1'b0) begin
                        r_out_valid <= 1'b1;
                        r_out_m     <= r_cnt[N-1:0];
                        r_out_s     <= r_tt[r_cnt[N-1:0]];
                        r_ones_cnt  <= r_ones_cnt + w_sweep_bit;
                        r_cnt       <= r_cnt + {{N{1'b0}}, 1'b1};
                        r_done      <= 1'b0;
                    end else begin
                        // Counter reached 2^N: every minterm has been produced.
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_cnt       <= {(N+1){1'b0}};
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_cnt       <= {(N+1){1'b0}};
                end
            endcase
        end
    end

    assign o_tt        = r_tt;
    assign o_out_valid = r_out_valid;
    assign o_out_m     = r_out_m;
    assign o_out_s     = r_out_s;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ones_cnt  = r_ones_cnt;

endmodule

// File: tb/tb_gate_lut_sweeper.sv
// Self-checking bench for gate_lut_sweeper (N=2). A table-level reference
// model holds the expected LUT and derives each output directly from the
// function's truth table and a popcount.
module tb_gate_lut_sweeper;

    localparam int N = 2;
    localparam int M = 4;

    logic           clk;
    logic           rst_n;
    logic           tt_load;
    logic [M-1:0]   tt_in;
    logic           in_valid;
    logic [N-1:0]   in_x;
    logic           start;
    logic [M-1:0]   tt;
    logic           out_valid;
    logic [N-1:0]   out_m;
    logic           out_s;
    logic           busy;
    logic           done;
    logic [N:0]     ones_cnt;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [M-1:0]   model_tt;

    gate_lut_sweeper #(.N(N), .TT_RST(4'b1101)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tt_load   (tt_load),
        .i_tt_in     (tt_in),
        .i_in_valid  (in_valid),
        .i_in_x      (in_x),
        .i_start     (start),
        .o_tt        (tt),
        .o_out_valid (out_valid),
        .o_out_m     (out_m),
        .o_out_s     (out_s),
        .o_busy      (busy),
        .o_done      (done),
        .o_ones_cnt  (ones_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        tt_load  = 1'b0;
        tt_in    = 4'b0000;
        in_valid = 1'b0;
        in_x     = 2'b00;
        start    = 1'b0;
    endtask

    // Number of ones among the minterms 0..k of the function.
    function automatic int ones_upto(input logic [M-1:0] f, input int k);
        int c = 0;
        for (int i = 0; i <= k; i++) c += int'(f[i]);
        return c;
    endfunction

    // Start a sweep and check every output cycle plus the done edge. With
    // disturb set, random load/start/in_valid traffic is applied while busy.
    // The task returns in the done cycle with the inputs idle.
    task automatic run_sweep(input bit disturb, input string tag);
        int vcount = 0;
        start = 1'b1;
        for (int k = 0; k < M; k++) begin
            tick();
            if (out_valid === 1'b1) vcount++;
            chk({tag, ".valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".m"},     32'(out_m),     32'(k));
            chk({tag, ".s"},     32'(out_s),     32'(model_tt[k]));
            chk({tag, ".ones"},  32'(ones_cnt),  32'(ones_upto(model_tt, k)));
            chk({tag, ".busy"},  32'(busy),      32'd1);
            chk({tag, ".done"},  32'(done),      32'd0);
            if (disturb) begin
                start    = 1'($urandom_range(1, 0));
                tt_load  = 1'($urandom_range(1, 0));
                tt_in    = 4'($urandom);
                in_valid = 1'($urandom_range(1, 0));
                in_x     = 2'($urandom);
            end else begin
                idle_inputs();
            end
        end
        tick();
        idle_inputs();
        chk({tag, ".end_busy"},  32'(busy),      32'd0);
        chk({tag, ".end_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".end_done"},  32'(done),      32'd1);
        chk({tag, ".end_ones"},  32'(ones_cnt),  32'($countones(model_tt)));
        chk({tag, ".end_tt"},    32'(tt),        32'(model_tt));
        chk({tag, ".vcount"},    32'(vcount),    32'(M));
    endtask

    initial begin
        logic [M-1:0] newtt;
        logic [N-1:0] x;

        // Reset held for two edges.
        idle_inputs();
        rst_n    = 1'b0;
        model_tt = 4'b1101;
        tick();
        tick();
        chk("rst.tt",    32'(tt),        32'(model_tt));
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.s",     32'(out_s),     32'd0);
        chk("rst.m",     32'(out_m),     32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        chk("rst.done",  32'(done),      32'd0);
        chk("rst.ones",  32'(ones_cnt),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("idle.valid", 32'(out_valid), 32'd0);
            chk("idle.busy",  32'(busy),      32'd0);
            chk("idle.done",  32'(done),      32'd0);
            chk("idle.ones",  32'(ones_cnt),  32'd0);
        end

        // Single evaluations with the default table (a | ~b).
        for (int i = 0; i < M; i++) begin
            in_valid = 1'b1;
            in_x     = 2'(i);
            tick();
            chk("eval.valid", 32'(out_valid), 32'd1);
            chk("eval.m",     32'(out_m),     32'(i));
            chk("eval.s",     32'(out_s),     32'(model_tt[i]));
            chk("eval.ones",  32'(ones_cnt),  32'd0);
        end
        idle_inputs();
        tick();
        chk("eval.idle_valid", 32'(out_valid), 32'd0);
        chk("eval.hold_m",     32'(out_m),     32'd3);

        // Default sweep followed by an idle edge that drops done.
        run_sweep(1'b0, "sw_def");
        tick();
        chk("sw_def.done_drop", 32'(done),     32'd0);
        chk("sw_def.ones_hold", 32'(ones_cnt), 32'd3);

        // Load XOR and sweep it.
        tt_load = 1'b1;
        tt_in   = 4'b0110;
        tick();
        model_tt = 4'b0110;
        idle_inputs();
        chk("load.tt",    32'(tt),        32'(model_tt));
        chk("load.valid", 32'(out_valid), 32'd0);
        run_sweep(1'b0, "sw_xor");
        tick();

        // start together with tt_load: the load wins, no sweep.
        newtt   = 4'b1001;
        tt_load = 1'b1;
        tt_in   = newtt;
        start   = 1'b1;
        tick();
        model_tt = newtt;
        idle_inputs();
        chk("col_start.tt",   32'(tt),        32'(model_tt));
        chk("col_start.busy", 32'(busy),      32'd0);
        tick();
        chk("col_start.busy2", 32'(busy),     32'd0);
        chk("col_start.valid", 32'(out_valid), 32'd0);

        // in_valid together with tt_load: no evaluation output.
        newtt    = 4'b0111;
        tt_load  = 1'b1;
        tt_in    = newtt;
        in_valid = 1'b1;
        in_x     = 2'b11;
        tick();
        model_tt = newtt;
        idle_inputs();
        chk("col_eval.valid", 32'(out_valid), 32'd0);
        chk("col_eval.tt",    32'(tt),        32'(model_tt));

        // Sweep with traffic while busy, then a start in the done cycle.
        run_sweep(1'b1, "sw_dist");
        run_sweep(1'b0, "sw_chain");
        tick();
        chk("sw_chain.done_drop", 32'(done), 32'd0);

        // Randomised tables: loads, single evaluations and sweeps.
        for (int r = 0; r < 8; r++) begin
            newtt   = 4'($urandom);
            tt_load = 1'b1;
            tt_in   = newtt;
            tick();
            model_tt = newtt;
            idle_inputs();
            chk("rnd.tt", 32'(tt), 32'(model_tt));
            for (int e = 0; e < 3; e++) begin
                x        = 2'($urandom);
                in_valid = 1'b1;
                in_x     = x;
                tick();
                idle_inputs();
                chk("rnd.eval_valid", 32'(out_valid), 32'd1);
                chk("rnd.eval_m",     32'(out_m),     32'(x));
                chk("rnd.eval_s",     32'(out_s),     32'(model_tt[x]));
            end
            run_sweep(1'($urandom_range(1, 0)), "sw_rnd");
            tick();
        end

        // Reset in the middle of a sweep.
        start = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("mid.m", 32'(out_m), 32'd1);
        rst_n = 1'b0;
        tick();
        model_tt = 4'b1101;
        chk("mid.busy",  32'(busy),      32'd0);
        chk("mid.valid", 32'(out_valid), 32'd0);
        chk("mid.ones",  32'(ones_cnt),  32'd0);
        chk("mid.tt",    32'(tt),        32'(model_tt));
        chk("mid.done",  32'(done),      32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid.no_done",  32'(done),      32'd0);
            chk("mid.no_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
